// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t    : fetch FSM states (REQ, WAIT, DROP, HOLD)
//   FETCH_INST_BYTES : size of one fetched instruction in bytes
//   FETCH_PC_STEP    : FETCH_INST_BYTES widened to the 64-bit PC width
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,   // issue a request for pc_q
        WAIT = 2'd1,   // request accepted, waiting for its response
        DROP = 2'd2,   // request went stale, swallow its response
        HOLD = 2'd3    // instruction presented to IF/ID
    } fetch_state_t;

    localparam int unsigned FETCH_INST_BYTES = 4;
    localparam logic [63:0] FETCH_PC_STEP    = 64'(FETCH_INST_BYTES);

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Keeps the fetch PC, issues one I-cache request at a
// time, captures the returned instruction with its PC and presents the pair to
// the IF/ID register. Redirects replace the fetch PC; a response that belongs
// to a pre-redirect request is discarded.
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   stall_in          : IF/ID not accepting, keep the presented instruction
//   redirect_valid    : branch/jump taken, redirect_pc replaces the fetch PC
//   redirect_pc[63:0] : new fetch PC (bits [1:0] ignored)
//   ic_req_valid      : I-cache request valid (combinational)
//   ic_req_ready      : I-cache accepts the request this cycle
//   ic_req_addr[63:0] : I-cache request address (= pc_q)
//   ic_resp_valid     : I-cache returns data this cycle
//   ic_resp_data[31:0]: returned instruction
//   instruction_out   : instruction to IF/ID (registered)
//   pc_out            : PC of instruction_out (registered)
//   icache_valid_out  : instruction_out/pc_out valid (registered)
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        ic_req_valid,
    input  logic        ic_req_ready,
    output logic [63:0] ic_req_addr,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_data,
    output logic [31:0] instruction_out,
    output logic [63:0] pc_out,
    output logic        icache_valid_out
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  req_pc_q, req_pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [63:0]  pc_out_q, pc_out_d;
    logic         valid_q, valid_d;

    logic [63:0]  redirect_pc_aligned;

    assign redirect_pc_aligned = {redirect_pc[63:2], 2'b00};

    // A redirect in REQ suppresses the request so a stale address is never
    // handed to the cache.
    assign ic_req_valid = (state_q == REQ) && !redirect_valid;
    assign ic_req_addr  = pc_q;

    assign instruction_out  = instr_q;
    assign pc_out           = pc_out_q;
    assign icache_valid_out = valid_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;

        case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc_aligned;
                end else if (ic_req_ready) begin
                    req_pc_d = pc_q;
                    state_d  = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc_aligned;
                    // The in-flight response is stale; if it is not here yet,
                    // DROP waits for it so it cannot be mistaken for a new one.
                    state_d = ic_resp_valid ? REQ : DROP;
                end else if (ic_resp_valid) begin
                    instr_d  = ic_resp_data;
                    pc_out_d = req_pc_q;
                    valid_d  = 1'b1;
                    pc_d     = req_pc_q + FETCH_PC_STEP;
                    state_d  = HOLD;
                end
            end

            DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc_aligned;
                end
                if (ic_resp_valid) begin
                    state_d = REQ;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_pc_aligned;
                    state_d = REQ;
                end else if (!stall_in) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end

            default: state_d = REQ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= 64'h0;
            instr_q  <= 32'h0;
            pc_out_q <= 64'h0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed, table-driven bench for fetch_unit (RESET_PC = 64'h1000). Each table
// row is one clock cycle: the inputs driven during that cycle and the outputs
// expected before the next rising edge. Hand-written sequences cover the
// ready-held-low and reset-during-WAIT cases.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        ic_req_valid;
    logic        ic_req_ready;
    logic [63:0] ic_req_addr;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_data;
    logic [31:0] instruction_out;
    logic [63:0] pc_out;
    logic        icache_valid_out;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_in         (stall_in),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .ic_req_valid     (ic_req_valid),
        .ic_req_ready     (ic_req_ready),
        .ic_req_addr      (ic_req_addr),
        .ic_resp_valid    (ic_resp_valid),
        .ic_resp_data     (ic_resp_data),
        .instruction_out  (instruction_out),
        .pc_out           (pc_out),
        .icache_valid_out (icache_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [63:0] redir_pc;
        logic        ready;
        logic        resp;
        logic [31:0] data;
        logic        exp_req_v;
        logic [63:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [63:0] exp_pc;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input logic stall, input logic redir, input logic [63:0] rpc,
                         input logic ready, input logic resp, input logic [31:0] data);
        stall_in       = stall;
        redirect_valid = redir;
        redirect_pc    = rpc;
        ic_req_ready   = ready;
        ic_resp_valid  = resp;
        ic_resp_data   = data;
    endtask

    task automatic check_outputs(input string tag, input logic req_v, input logic [63:0] addr,
                                 input logic valid, input logic [31:0] instr,
                                 input logic [63:0] pc);
        check({tag, ".req_valid"}, 64'(ic_req_valid), 64'(req_v));
        check({tag, ".req_addr"},  ic_req_addr, addr);
        check({tag, ".valid"},     64'(icache_valid_out), 64'(valid));
        check({tag, ".instr"},     64'(instruction_out), 64'(instr));
        check({tag, ".pc_out"},    pc_out, pc);
    endtask

    vec_t vecs[$];

    // stall redir redir_pc ready resp data | req_v addr valid instr pc
    function automatic vec_t mk(logic s, logic r, logic [63:0] rp, logic rdy, logic rv,
                                logic [31:0] d, logic erv, logic [63:0] ea, logic ev,
                                logic [31:0] ei, logic [63:0] ep);
        vec_t v;
        v.stall = s;  v.redir = r;  v.redir_pc = rp; v.ready = rdy; v.resp = rv;
        v.data = d;   v.exp_req_v = erv; v.exp_addr = ea; v.exp_valid = ev;
        v.exp_instr = ei; v.exp_pc = ep;
        return v;
    endfunction

    initial begin
        // Back-to-back stream 1000/1004/1008, one instruction per 3 cycles.
        vecs.push_back(mk(0,0,64'h0,1,0,32'h0,        1,64'h1000,0,32'h0,64'h0));      // 0 REQ
        vecs.push_back(mk(0,0,64'h0,1,1,32'hA1A1A1A1, 0,64'h1000,0,32'h0,64'h0));      // 1 WAIT resp
        vecs.push_back(mk(0,0,64'h0,0,0,32'h0,        0,64'h1004,1,32'hA1A1A1A1,64'h1000)); // 2 HOLD
        vecs.push_back(mk(0,0,64'h0,1,0,32'h0,        1,64'h1004,0,32'hA1A1A1A1,64'h1000)); // 3 REQ
        vecs.push_back(mk(0,0,64'h0,1,1,32'hA2A2A2A2, 0,64'h1004,0,32'hA1A1A1A1,64'h1000)); // 4 WAIT
        vecs.push_back(mk(0,0,64'h0,0,0,32'h0,        0,64'h1008,1,32'hA2A2A2A2,64'h1004)); // 5 HOLD
        vecs.push_back(mk(0,0,64'h0,1,0,32'h0,        1,64'h1008,0,32'hA2A2A2A2,64'h1004)); // 6 REQ
        // Response 0x00500093 then three stalled cycles.
        vecs.push_back(mk(0,0,64'h0,1,1,32'h00500093, 0,64'h1008,0,32'hA2A2A2A2,64'h1004)); // 7 WAIT
        vecs.push_back(mk(1,0,64'h0,1,0,32'h0,        0,64'h100C,1,32'h00500093,64'h1008)); // 8 stall
        vecs.push_back(mk(1,0,64'h0,1,0,32'h0,        0,64'h100C,1,32'h00500093,64'h1008)); // 9 stall
        vecs.push_back(mk(1,0,64'h0,1,0,32'h0,        0,64'h100C,1,32'h00500093,64'h1008)); // 10 stall
        vecs.push_back(mk(0,0,64'h0,1,0,32'h0,        0,64'h100C,1,32'h00500093,64'h1008)); // 11 consumed
        vecs.push_back(mk(0,0,64'h0,1,0,32'h0,        1,64'h100C,0,32'h00500093,64'h1008)); // 12 REQ 100C
        // Redirect to 0x2002 in WAIT, stale 0xDEADBEEF dropped in DROP.
        vecs.push_back(mk(0,1,64'h2002,0,0,32'h0,     0,64'h100C,0,32'h00500093,64'h1008)); // 13 -> DROP
        vecs.push_back(mk(0,0,64'h0,0,1,32'hDEADBEEF, 0,64'h2000,0,32'h00500093,64'h1008)); // 14 drop
        vecs.push_back(mk(0,0,64'h0,1,0,32'h0,        1,64'h2000,0,32'h00500093,64'h1008)); // 15 REQ 2000
        // Redirect in the same cycle as the WAIT response.
        vecs.push_back(mk(0,1,64'h3000,0,1,32'h11111111,0,64'h2000,0,32'h00500093,64'h1008)); // 16
        vecs.push_back(mk(0,0,64'h0,0,0,32'h0,        1,64'h3000,0,32'h00500093,64'h1008)); // 17 REQ 3000
        vecs.push_back(mk(0,0,64'h0,1,0,32'h0,        1,64'h3000,0,32'h00500093,64'h1008)); // 18 accept
        vecs.push_back(mk(0,0,64'h0,0,1,32'h22222222, 0,64'h3000,0,32'h00500093,64'h1008)); // 19 resp
        // Redirect in HOLD while stalled.
        vecs.push_back(mk(1,1,64'h4000,0,0,32'h0,     0,64'h3004,1,32'h22222222,64'h3000)); // 20
        vecs.push_back(mk(0,0,64'h0,0,0,32'h0,        1,64'h4000,0,32'h22222222,64'h3000)); // 21 REQ 4000
        // Redirect in REQ suppresses the request even with ready high.
        vecs.push_back(mk(0,1,64'h5001,1,0,32'h0,     0,64'h4000,0,32'h22222222,64'h3000)); // 22
        vecs.push_back(mk(0,0,64'h0,1,0,32'h0,        1,64'h5000,0,32'h22222222,64'h3000)); // 23 accept
        // DROP with a redirect, then redirect + stale response together in DROP.
        vecs.push_back(mk(0,1,64'h6000,0,0,32'h0,     0,64'h5000,0,32'h22222222,64'h3000)); // 24 -> DROP
        vecs.push_back(mk(0,1,64'h7000,0,1,32'h33333333,0,64'h6000,0,32'h22222222,64'h3000)); // 25 -> REQ
        vecs.push_back(mk(0,0,64'h0,1,0,32'h0,        1,64'h7000,0,32'h22222222,64'h3000)); // 26 accept
        vecs.push_back(mk(0,0,64'h0,0,1,32'h44444444, 0,64'h7000,0,32'h22222222,64'h3000)); // 27 resp
        vecs.push_back(mk(0,0,64'h0,0,0,32'h0,        0,64'h7004,1,32'h44444444,64'h7000)); // 28 HOLD
        // Unsolicited response in REQ is ignored.
        vecs.push_back(mk(0,0,64'h0,0,1,32'h55555555, 1,64'h7004,0,32'h44444444,64'h7000)); // 29
        vecs.push_back(mk(0,0,64'h0,0,0,32'h0,        1,64'h7004,0,32'h44444444,64'h7000)); // 30
        // PC increment wraps modulo 2^64; low redirect bits are masked.
        vecs.push_back(mk(0,1,64'hFFFF_FFFF_FFFF_FFFF,0,0,32'h0, 0,64'h7004,0,32'h44444444,64'h7000)); // 31
        vecs.push_back(mk(0,0,64'h0,1,0,32'h0,        1,64'hFFFF_FFFF_FFFF_FFFC,0,32'h44444444,64'h7000)); // 32
        vecs.push_back(mk(0,0,64'h0,0,1,32'h66666666, 0,64'hFFFF_FFFF_FFFF_FFFC,0,32'h44444444,64'h7000)); // 33
        vecs.push_back(mk(0,0,64'h0,0,0,32'h0,        0,64'h0,1,32'h66666666,64'hFFFF_FFFF_FFFF_FFFC)); // 34
        vecs.push_back(mk(0,0,64'h0,0,0,32'h0,        1,64'h0,0,32'h66666666,64'hFFFF_FFFF_FFFF_FFFC)); // 35

        // Reset: registered outputs read zero, fetch address is RESET_PC.
        reset = 1'b1;
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        #12;
        check("rst.valid",  64'(icache_valid_out), 64'h0);
        check("rst.instr",  64'(instruction_out), 64'h0);
        check("rst.pc_out", pc_out, 64'h0);
        check("rst.addr",   ic_req_addr, RST_PC);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].stall, vecs[i].redir, vecs[i].redir_pc,
                  vecs[i].ready, vecs[i].resp, vecs[i].data);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_req_v, vecs[i].exp_addr,
                          vecs[i].exp_valid, vecs[i].exp_instr, vecs[i].exp_pc);
        end

        // ic_req_ready low for 4 cycles in REQ: request held, address stable.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 0, 64'h0, 0, 0, 32'h0);
            #1;
            check_outputs($sformatf("nordy%0d", k), 1'b1, 64'h0, 1'b0, 32'h66666666,
                          64'hFFFF_FFFF_FFFF_FFFC);
        end
        @(negedge clk);
        drive(0, 0, 64'h0, 1, 0, 32'h0);      // accepted -> WAIT
        #1;
        check("acc.req_valid", 64'(ic_req_valid), 64'h1);
        @(negedge clk);
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        #1;
        check("wait.req_valid", 64'(ic_req_valid), 64'h0);

        // Reset asserted while in WAIT, late response afterwards.
        reset = 1'b1;
        #1;
        check("rstw.valid",  64'(icache_valid_out), 64'h0);
        check("rstw.instr",  64'(instruction_out), 64'h0);
        check("rstw.pc_out", pc_out, 64'h0);
        check("rstw.addr",   ic_req_addr, RST_PC);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 64'h0, 0, 1, 32'h77777777);  // late response, ready low
        #1;
        check_outputs("late0", 1'b1, RST_PC, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
        drive(0, 0, 64'h0, 1, 0, 32'h0);
        #1;
        check_outputs("late1", 1'b1, RST_PC, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
        drive(0, 0, 64'h0, 0, 1, 32'h88888888);
        #1;
        check_outputs("late2", 1'b0, RST_PC, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        #1;
        check_outputs("late3", 1'b0, RST_PC + 64'd4, 1'b1, 32'h88888888, RST_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_unit
